// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-wide RAM port between instruction fetch and load/store,
// one byte per cycle, little-endian word assembly.
// Ports: clk, rst (sync, active-high); if_req/if_addr -> if_ready/if_data (word reads);
// mem_req/mem_we/mem_size/mem_addr/mem_wdata -> mem_ready/mem_rdata;
// ram_addr/ram_wr/ram_dout (registered) and ram_din (valid RD_LAT cycles after ram_addr).
// Optional MEM_ARB_RR_EN: round-robin between simultaneous requesters instead of MEM priority.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_ready,
  output logic [31:0]       if_data,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_size,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic              mem_ready,
  output logic [31:0]       mem_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wr,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din
);
  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
  state_t state_q, state_d;
  logic sel_mem_q, sel_mem_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [2:0] cnt_q, cnt_d;
  logic [1:0] nm1_q, nm1_d;
  logic [31:0] wdata_q, wdata_d, asm_q, asm_d, if_data_q, if_data_d, mem_rdata_q, mem_rdata_d;
  logic ram_wr_q, ram_wr_d;
  logic [7:0] ram_dout_q, ram_dout_d;
  logic gnt_mem, gnt_if, grant, last_cap, last_wr, cap;
  logic [1:0] lane;
`ifdef MEM_ARB_RR_EN
  logic last_mem_q, last_mem_d;
  assign gnt_mem = mem_req && (!if_req || !last_mem_q);
  assign last_mem_d = grant ? gnt_mem : last_mem_q;
  always_ff @(posedge clk) last_mem_q <= rst ? 1'b1 : last_mem_d;
`else
  assign gnt_mem = mem_req;
`endif
  assign gnt_if = if_req && !gnt_mem;
  assign grant = state_q == IDLE && (gnt_mem || gnt_if);
  // cnt counts cycles since grant; read byte k lands when cnt reaches k+RD_LAT
  assign last_cap = cnt_q == {1'b0, nm1_q} + 3'(RD_LAT);
  assign last_wr = cnt_q[1:0] == nm1_q;
  assign cap = cnt_q >= 3'(RD_LAT);
  assign lane = 2'(cnt_q - 3'(RD_LAT));
  always_ff @(posedge clk) state_q <= rst ? IDLE : state_d;
  always_comb
    state_d = state_q == IDLE ? (gnt_mem && mem_we ? WR : grant ? RD : IDLE) :
              state_q == RD   ? (last_cap ? DONE : RD) :
              state_q == WR   ? (last_wr ? DONE : WR) : IDLE;
  always_comb begin
    if_ready = state_q == DONE && !sel_mem_q;
    mem_ready = state_q == DONE && sel_mem_q;
  end
  always_comb begin
    sel_mem_d = sel_mem_q;
    ram_addr_d = ram_addr_q;
    cnt_d = cnt_q;
    nm1_d = nm1_q;
    wdata_d = wdata_q;
    asm_d = asm_q;
    if_data_d = if_data_q;
    mem_rdata_d = mem_rdata_q;
    ram_wr_d = ram_wr_q;
    ram_dout_d = ram_dout_q;
    if (grant) begin
      sel_mem_d = gnt_mem;
      ram_addr_d = gnt_mem ? mem_addr[ADDR_W-1:0] : if_addr[ADDR_W-1:0];
      cnt_d = '0;
      nm1_d = !gnt_mem || mem_size[1] ? 2'd3 : {1'b0, mem_size[0]};
      asm_d = '0;
      ram_wr_d = gnt_mem && mem_we;
      ram_dout_d = mem_wdata[7:0];
      wdata_d = mem_wdata >> 8;
    end else if (state_q == RD) begin
      cnt_d = cnt_q + 3'd1;
      if (cnt_q < {1'b0, nm1_q}) ram_addr_d = ram_addr_q + ADDR_W'(1);
      if (cap) asm_d[{lane, 3'b000} +: 8] = ram_din;
      if (last_cap && sel_mem_q) mem_rdata_d = asm_d;
      if (last_cap && !sel_mem_q) if_data_d = asm_d;
    end else if (state_q == WR) begin
      cnt_d = cnt_q + 3'd1;
      ram_wr_d = !last_wr;
      if (!last_wr) begin
        ram_addr_d = ram_addr_q + ADDR_W'(1);
        ram_dout_d = wdata_q[7:0];
        wdata_d = wdata_q >> 8;
      end
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      sel_mem_q <= 1'b0;
      ram_addr_q <= '0;
      cnt_q <= '0;
      nm1_q <= '0;
      wdata_q <= '0;
      asm_q <= '0;
      if_data_q <= '0;
      mem_rdata_q <= '0;
      ram_wr_q <= 1'b0;
      ram_dout_q <= '0;
    end else begin
      sel_mem_q <= sel_mem_d;
      ram_addr_q <= ram_addr_d;
      cnt_q <= cnt_d;
      nm1_q <= nm1_d;
      wdata_q <= wdata_d;
      asm_q <= asm_d;
      if_data_q <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
      ram_wr_q <= ram_wr_d;
      ram_dout_q <= ram_dout_d;
    end
  assign if_data = if_data_q;
  assign mem_rdata = mem_rdata_q;
  assign ram_addr = ram_addr_q;
  assign ram_wr = ram_wr_q;
  assign ram_dout = ram_dout_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: transaction-schedule model plus directed literal checks for mem_arbiter
module tb_mem_arbiter;
  localparam int NC = 1024;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic if_req = 0, if_req2 = 0;
  logic [31:0] if_addr = 0, if_addr2 = 0;
  logic if_ready, if_ready2, mem_ready, mem_ready2;
  logic [31:0] if_data, if_data2, mem_rdata, mem_rdata2;
  logic mem_req = 0, mem_we = 0;
  logic [1:0] mem_size = 0;
  logic [31:0] mem_addr = 0, mem_wdata = 0;
  logic [31:0] ram_addr, ram_addr2;
  logic ram_wr, ram_wr2;
  logic [7:0] ram_dout, ram_dout2, ram_din, ram_din2;
  logic pl_en = 0;
  logic [11:0] pl_a = 0;
  logic [7:0] pl_d = 0;
  int checks = 0, failures = 0, cyc = 0;
  mem_arbiter #(.ADDR_W(32), .RD_LAT(1)) u1 (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_data(if_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .ram_addr(ram_addr), .ram_wr(ram_wr),
    .ram_dout(ram_dout), .ram_din(ram_din));
  mem_arbiter #(.ADDR_W(32), .RD_LAT(2)) u2 (
    .clk(clk), .rst(rst), .if_req(if_req2), .if_addr(if_addr2), .if_ready(if_ready2), .if_data(if_data2),
    .mem_req(1'b0), .mem_we(1'b0), .mem_size(2'd0), .mem_addr(32'd0), .mem_wdata(32'd0),
    .mem_ready(mem_ready2), .mem_rdata(mem_rdata2), .ram_addr(ram_addr2), .ram_wr(ram_wr2),
    .ram_dout(ram_dout2), .ram_din(ram_din2));
  logic [7:0] ram1 [0:4095];
  logic [7:0] ram2 [0:4095];
  logic [31:0] a1, b1, b2;
  always @(posedge clk) begin
    if (pl_en) begin
      ram1[pl_a] <= pl_d;
      ram2[pl_a] <= pl_d;
    end else begin
      if (ram_wr) ram1[ram_addr[11:0]] <= ram_dout;
      if (ram_wr2) ram2[ram_addr2[11:0]] <= ram_dout2;
    end
    a1 <= ram_addr;
    b1 <= ram_addr2;
    b2 <= b1;
  end
  assign ram_din = ram1[a1[11:0]];
  assign ram_din2 = ram2[b2[11:0]];
  bit e_chka [NC];
  bit e_wr [NC];
  bit e_ifr [NC];
  bit e_memr [NC];
  bit e_upd [NC];
  bit e_rst [NC];
  logic [31:0] e_addr [NC];
  logic [7:0] e_dout [NC];
  logic [31:0] e_dat [NC];
  logic [7:0] sh [0:4095];
  byte dlog [64];
  int nlog = 0;
  logic [31:0] seen [16];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask
  initial begin : model
    int e, free_at, n, r;
    bit gm, we;
    logic [31:0] a, t, d;
`ifdef MEM_ARB_RR_EN
    bit last_mem;
    last_mem = 1;
`endif
    free_at = 0;
    for (int i = 0; i < 4096; i++) sh[i] = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      e = cyc;
      if (e < NC - 16) begin
        if (pl_en) sh[pl_a] = pl_d;
        if (e_wr[e-1]) begin
          t = e_addr[e-1];
          sh[t[11:0]] = e_dout[e-1];
        end
        if (rst) begin
          for (int j = e; j < NC; j++) begin
            e_chka[j] = 0; e_wr[j] = 0; e_ifr[j] = 0; e_memr[j] = 0; e_upd[j] = 0; e_rst[j] = 0;
          end
          e_rst[e] = 1;
          e_chka[e] = 1;
          e_addr[e] = 0;
          free_at = e + 1;
`ifdef MEM_ARB_RR_EN
          last_mem = 1;
`endif
        end else if (e >= free_at && (if_req || mem_req)) begin
`ifdef MEM_ARB_RR_EN
          gm = mem_req && (!if_req || !last_mem);
          last_mem = gm;
`else
          gm = mem_req;
`endif
          we = gm && mem_we;
          a = gm ? mem_addr : if_addr;
          n = !gm ? 4 : mem_size == 0 ? 1 : mem_size == 1 ? 2 : 4;
          d = 0;
          for (int k = 0; k < n; k++) begin
            t = a + k;
            e_chka[e+k] = 1;
            e_addr[e+k] = t;
            if (we) begin
              e_wr[e+k] = 1;
              e_dout[e+k] = mem_wdata[8*k +: 8];
            end
            d[8*k +: 8] = sh[t[11:0]];
          end
          r = e + n + (we ? 0 : 1);
          if (gm) e_memr[r] = 1; else e_ifr[r] = 1;
          e_upd[r] = !we;
          e_dat[r] = d;
          free_at = r + 2;
        end
      end
    end
  end
  initial begin : cmp
    logic [31:0] h_if, h_mem;
    int c;
    h_if = 0;
    h_mem = 0;
    forever begin
      @(negedge clk);
      c = cyc;
      if (c >= 1 && c < NC) begin
        if (e_rst[c]) begin
          h_if = 0;
          h_mem = 0;
        end
        if (e_upd[c] && e_ifr[c]) h_if = e_dat[c];
        if (e_upd[c] && e_memr[c]) h_mem = e_dat[c];
        chk("if_ready", {31'd0, if_ready}, {31'd0, e_ifr[c]});
        chk("mem_ready", {31'd0, mem_ready}, {31'd0, e_memr[c]});
        chk("ram_wr", {31'd0, ram_wr}, {31'd0, e_wr[c]});
        chk("if_data", if_data, h_if);
        chk("mem_rdata", mem_rdata, h_mem);
        if (e_chka[c]) chk("ram_addr", ram_addr, e_addr[c]);
        if (e_wr[c]) chk("ram_dout", {24'd0, ram_dout}, {24'd0, e_dout[c]});
        if (if_ready && nlog < 64) dlog[nlog++] = "I";
        if (mem_ready && nlog < 64) dlog[nlog++] = "M";
      end
    end
  end
  task automatic if_txn(input logic [31:0] a, output logic [31:0] d, output int lat);
    bit got;
    got = 0;
    lat = -1;
    d = 'x;
    if_req = 1;
    if_addr = a;
    for (int m = 1; m <= 60 && !got; m++) begin
      @(negedge clk);
      if (m < 16) seen[m] = ram_addr;
      if (if_ready) begin
        got = 1;
        d = if_data;
        lat = m - 2;
      end
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL if_timeout addr=%h got=no_ready want=if_ready", a);
    end
    @(posedge clk);
    #1 if_req = 0;
  endtask
  task automatic mem_txn(input bit we, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                         input bit scr, output logic [31:0] d, output int lat);
    bit got;
    got = 0;
    lat = -1;
    d = 'x;
    mem_req = 1;
    mem_we = we;
    mem_size = sz;
    mem_addr = a;
    mem_wdata = wd;
    for (int m = 1; m <= 60 && !got; m++) begin
      @(negedge clk);
      if (scr && m == 3) begin
        mem_addr = ~a;
        mem_wdata = ~wd;
        mem_size = ~sz;
      end
      if (mem_ready) begin
        got = 1;
        d = mem_rdata;
        lat = m - 2;
      end
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL mem_timeout addr=%h got=no_ready want=mem_ready", a);
    end
    @(posedge clk);
    #1 mem_req = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1);
  end
  initial begin : main
    logic [31:0] d, d1;
    int lat, l1, s;
    logic [11:0] pa [7];
    logic [7:0] pd [7];
    pa = '{12'h000, 12'h001, 12'h002, 12'h003, 12'hFFE, 12'hFFF, 12'h203};
    pd = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hA5, 8'h5A, 8'h00};
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 7; i++) begin
      pl_en = 1;
      pl_a = pa[i];
      pl_d = pd[i];
      @(posedge clk);
      #1;
    end
    pl_en = 0;
    @(negedge clk);
    chk("rst_ram_addr", ram_addr, 32'd0);
    chk("rst_if_ready", {31'd0, if_ready}, 32'd0);
    @(posedge clk);
    #1 rst = 0;
    if_txn(32'h0, d, lat);
    chk("t1_if_data", d, 32'h44332211);
    chk("t1_latency", lat, 5);
    mem_txn(1, 2'd2, 32'h100, 32'hDEADBEEF, 1, d, lat);
    chk("t2_latency", lat, 4);
    mem_txn(0, 2'd2, 32'h100, 32'h0, 0, d, lat);
    chk("t2_readback", d, 32'hDEADBEEF);
    mem_txn(0, 2'd0, 32'h101, 32'h0, 0, d, lat);
    chk("t3_byte", d, 32'h000000BE);
    chk("t3_byte_lat", lat, 2);
    mem_txn(0, 2'd1, 32'h102, 32'h0, 0, d, lat);
    chk("t3_half", d, 32'h0000DEAD);
    chk("t3_half_lat", lat, 3);
    if_txn(32'hFFFFFFFE, d, lat);
    chk("t5_data", d, 32'h22115AA5);
    chk("t5_addr0", seen[2], 32'hFFFFFFFE);
    chk("t5_addr1", seen[3], 32'hFFFFFFFF);
    chk("t5_addr2", seen[4], 32'h00000000);
    chk("t5_addr3", seen[5], 32'h00000001);
    chk("t5_if_hold", if_data, 32'h22115AA5);
    s = nlog;
    fork
      if_txn(32'h0, d1, l1);
      mem_txn(0, 2'd2, 32'h0, 32'h0, 0, d, lat);
    join
    chk("t4_first", {24'd0, dlog[s]}, {24'd0, 8'("M")});
    chk("t4_second", {24'd0, dlog[s+1]}, {24'd0, 8'("I")});
    chk("t4_if_data", d1, 32'h44332211);
    chk("t4_mem_data", d, 32'h44332211);
    chk("t4_if_lat", l1, 12);
    s = nlog;
    fork
      begin
        if_txn(32'h1, d1, l1);
        if_txn(32'h2, d1, l1);
      end
      begin
        mem_txn(0, 2'd0, 32'h3, 32'h0, 0, d, lat);
        mem_txn(0, 2'd0, 32'h0, 32'h0, 0, d, lat);
      end
    join
    chk("t4c_g0", {24'd0, dlog[s]}, {24'd0, 8'("M")});
`ifdef MEM_ARB_RR_EN
    chk("t4c_g1", {24'd0, dlog[s+1]}, {24'd0, 8'("I")});
    chk("t4c_g2", {24'd0, dlog[s+2]}, {24'd0, 8'("M")});
`else
    chk("t4c_g1", {24'd0, dlog[s+1]}, {24'd0, 8'("M")});
    chk("t4c_g2", {24'd0, dlog[s+2]}, {24'd0, 8'("I")});
`endif
    chk("t4c_g3", {24'd0, dlog[s+3]}, {24'd0, 8'("I")});
    mem_req = 1;
    mem_we = 1;
    mem_size = 2'd2;
    mem_addr = 32'h200;
    mem_wdata = 32'hCAFEF00D;
    repeat (3) @(posedge clk);
    #1;
    rst = 1;
    mem_req = 0;
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("t6_ram_wr", {31'd0, ram_wr}, 32'd0);
    chk("t6_mem_ready", {31'd0, mem_ready}, 32'd0);
    chk("t6_rdata_clr", mem_rdata, 32'd0);
    @(posedge clk);
    #1;
    mem_txn(0, 2'd2, 32'h200, 32'h0, 0, d, lat);
    chk("t6_partial", d, 32'h00FEF00D);
    chk("t6_idle_lat", lat, 5);
    begin
      bit got;
      got = 0;
      lat = -1;
      if_req2 = 1;
      if_addr2 = 32'h0;
      for (int m = 1; m <= 60 && !got; m++) begin
        @(negedge clk);
        if (if_ready2) begin
          got = 1;
          d = if_data2;
          lat = m - 2;
        end
      end
      chk("t6b_latency", lat, 6);
      chk("t6b_data", d, 32'h44332211);
      @(posedge clk);
      #1 if_req2 = 0;
    end
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
